// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed from a valid/ready byte FIFO dequeue port.
// One byte in flight; ready reopens in the final stop-bit cycle for gapless back-to-back frames.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  // Keep the counter at least one bit wide when a bit lasts a single cycle.
  localparam int CNT_W = (CLOCK_COUNTER_WIDTH < 1) ? 1 : CLOCK_COUNTER_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [3:0] DATA_LAST_IDX = 4'd8;
  localparam logic [3:0] STOP_IDX      = 4'd9;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [3:0]       bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             serial_nxt;
  logic             bit_end;
  logic             fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_idx    <= 4'd0;
      cnt        <= '0;
      shift      <= 8'd0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_nxt;
      bit_idx    <= bit_idx_nxt;
      cnt        <= cnt_nxt;
      shift      <= shift_nxt;
      serial_out <= serial_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_idx_nxt   = bit_idx;
    cnt_nxt       = cnt;
    shift_nxt     = shift;
    serial_nxt    = serial_out;
    bit_end       = (cnt == CNT_LAST);
    data_in_ready = (state == IDLE) || (bit_end && (bit_idx == STOP_IDX));
    fire          = data_in_valid && data_in_ready;

    if (fire) begin
      state_nxt   = SEND;
      bit_idx_nxt = 4'd0;
      cnt_nxt     = '0;
      shift_nxt   = data_in;
      serial_nxt  = 1'b0;
    end else if (state == SEND) begin
      if (!bit_end) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else if (bit_idx == STOP_IDX) begin
        state_nxt   = IDLE;
        bit_idx_nxt = 4'd0;
        cnt_nxt     = '0;
        serial_nxt  = 1'b1;
      end else begin
        cnt_nxt     = '0;
        bit_idx_nxt = bit_idx + 4'd1;
        // Leaving the last data bit drives the stop bit; otherwise shift out the next LSB.
        if (bit_idx == DATA_LAST_IDX) begin
          serial_nxt = 1'b1;
        end else begin
          serial_nxt = shift[0];
          shift_nxt  = {1'b0, shift[7:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized bench for uart_transmitter against a frame-timeline reference model.
module tb_uart_transmitter;

  localparam int CF = 1000;
  localparam int BR = 100;
  localparam int S  = CF / BR;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;

  uart_transmitter #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: the current frame spans cycles f_start..f_end with its 10 line bits.
  int       f_start = 0;
  int       f_end   = 0;
  bit [9:0] f_bits  = 10'h3FF;

  bit mon_en = 1'b0;
  bit mon_prev = 1'b1;
  int mon_run = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_ready(input int c);
    return c >= f_end;
  endfunction

  function automatic bit model_serial(input int c);
    if (c >= f_start && c <= f_end) return f_bits[(c - f_start) / S];
    return 1'b1;
  endfunction

  task automatic cycle(output bit fired);
    @(negedge clk);
    if (chk_en) begin
      chk("ready", int'(data_in_ready), int'(model_ready(cyc)));
      chk("serial", int'(serial_out), int'(model_serial(cyc)));
    end
    if (mon_en) begin
      if (serial_out == mon_prev) begin
        mon_run++;
      end else begin
        if (mon_prev == 1'b0) chk("low_run_multiple", mon_run % S, 0);
        else                  chk("high_run_min", int'(mon_run >= S), 1);
        mon_prev = serial_out;
        mon_run  = 1;
      end
    end
    fired = data_in_valid && model_ready(cyc) && !reset;
    @(posedge clk);
    if (reset) begin
      f_start = 0;
      f_end   = 0;
    end else if (fired) begin
      f_start = cyc + 1;
      f_end   = cyc + 10 * S;
      f_bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) f_bits[k + 1] = data_in[k];
      f_bits[9] = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bit f;
    data_in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(f);
  endtask

  // Hold valid with byte b until the model accepts it; optionally keep valid high afterwards.
  task automatic send_byte(input logic [7:0] b, input bit keep_valid);
    bit f;
    int waited;
    f = 1'b0;
    waited = 0;
    data_in = b;
    data_in_valid = 1'b1;
    while (!f && waited < 300) begin
      cycle(f);
      waited++;
    end
    if (!f) chk("fire_timeout", 0, 1);
    data_in = 8'($urandom);
    if (!keep_valid) data_in_valid = 1'b0;
  endtask

  initial begin
    bit f;
    reset = 1'b1;
    cycle(f);
    cycle(f);
    reset = 1'b0;
    chk_en = 1'b1;

    // Idle after reset: line high, ready high.
    idle(50);

    // Single byte.
    send_byte(8'hA5, 1'b0);
    idle(110);

    // Back-to-back with valid held high.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b0);
    idle(110);

    // Offered byte while busy must wait for the stop-bit slot.
    send_byte(8'h3C, 1'b0);
    idle(4);
    send_byte(8'hFF, 1'b0);
    idle(110);

    // Reset mid-frame, then a clean new frame.
    send_byte(8'h55, 1'b0);
    idle(44);
    reset = 1'b1;
    cycle(f);
    reset = 1'b0;
    idle(4);
    send_byte(8'h0F, 1'b0);
    idle(110);

    // Random bytes with random gaps, bit-width monitor active.
    mon_en   = 1'b1;
    mon_prev = 1'b1;
    mon_run  = S;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 15));
      send_byte(8'($urandom), ($urandom_range(0, 1) == 1));
    end
    idle(110);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
